// File: rtl/alu_seq_exec.sv
// alu_seq_exec: execute-stage ALU behind a valid/ready handshake.
// Logic, arithmetic and compare ops produce their result one cycle after accept.
// Shifts run on an iterative 1-bit-per-cycle shifter by default. Defining
// ALU_FAST_SHIFT_EN replaces it with a single-cycle barrel shifter.
// Result, Zero, Overflow and Illegal are held until downstream takes them.
module alu_seq_exec #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic               CLK,
    input  logic               Reset_L,
    input  logic               InValid,
    output logic               InReady,
    input  logic [3:0]         ALUCtrl,
    input  logic [WIDTH-1:0]   BusA,
    input  logic [WIDTH-1:0]   BusB,
    input  logic [SHAMT_W-1:0] Shamt,
    output logic               OutValid,
    input  logic               OutReady,
    output logic [WIDTH-1:0]   BusW,
    output logic               Zero,
    output logic               Overflow,
    output logic               Illegal
);

    localparam int unsigned MSB = WIDTH - 1;

    // ALU control encodings shared with the ALU control decoder
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SLL  = 4'b0011;
    localparam logic [3:0] ALU_SRL  = 4'b0100;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_ADDU = 4'b1000;
    localparam logic [3:0] ALU_SUBU = 4'b1001;
    localparam logic [3:0] ALU_XOR  = 4'b1010;
    localparam logic [3:0] ALU_SLTU = 4'b1011;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

`ifdef ALU_FAST_SHIFT_EN
    typedef enum logic {ST_IDLE, ST_DONE} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;
`endif

    state_t             state, state_next;
    logic [WIDTH-1:0]   bus_w_next;
    logic               zero_next, ovf_next, ill_next;
    logic [WIDTH-1:0]   alu_res, sum, diff;
    logic               alu_ovf, alu_ill, is_shift;
`ifndef ALU_FAST_SHIFT_EN
    logic [SHAMT_W-1:0] cnt, cnt_next;
    logic [3:0]         op_q, op_next;
    logic [WIDTH-1:0]   step;
`endif

    // Single-cycle result for the incoming request; shifts yield BusB when iterative
    always_comb begin
        alu_res  = '0;
        alu_ovf  = 1'b0;
        alu_ill  = 1'b0;
        is_shift = 1'b0;
        sum      = BusA + BusB;
        diff     = BusA - BusB;
        case (ALUCtrl)
            ALU_ADD: begin
                alu_res = sum;
                alu_ovf = (BusA[MSB] == BusB[MSB]) && (sum[MSB] != BusA[MSB]);
            end
            ALU_SUB: begin
                alu_res = diff;
                alu_ovf = (BusA[MSB] != BusB[MSB]) && (diff[MSB] != BusA[MSB]);
            end
            ALU_ADDU: alu_res = sum;
            ALU_SUBU: alu_res = diff;
            ALU_AND:  alu_res = BusA & BusB;
            ALU_OR:   alu_res = BusA | BusB;
            ALU_XOR:  alu_res = BusA ^ BusB;
            ALU_NOR:  alu_res = ~(BusA | BusB);
            ALU_SLT:  alu_res = WIDTH'($signed(BusA) < $signed(BusB));
            ALU_SLTU: alu_res = WIDTH'(BusA < BusB);
`ifdef ALU_FAST_SHIFT_EN
            ALU_SLL: begin is_shift = 1'b1; alu_res = BusB << Shamt; end
            ALU_SRL: begin is_shift = 1'b1; alu_res = BusB >> Shamt; end
            ALU_SRA: begin is_shift = 1'b1; alu_res = WIDTH'($signed(BusB) >>> Shamt); end
`else
            ALU_SLL, ALU_SRL, ALU_SRA: begin is_shift = 1'b1; alu_res = BusB; end
`endif
            default:  alu_ill = 1'b1;
        endcase
    end

`ifndef ALU_FAST_SHIFT_EN
    // One-bit shift of the working value for the latched shift kind
    always_comb begin
        step = BusW;
        case (op_q)
            ALU_SLL: step = {BusW[MSB-1:0], 1'b0};
            ALU_SRL: step = {1'b0, BusW[MSB:1]};
            default: step = {BusW[MSB], BusW[MSB:1]};
        endcase
    end
`endif

    // Next state and next register values
    always_comb begin
        state_next = state;
        bus_w_next = BusW;
        zero_next  = Zero;
        ovf_next   = Overflow;
        ill_next   = Illegal;
`ifndef ALU_FAST_SHIFT_EN
        cnt_next   = cnt;
        op_next    = op_q;
`endif
        case (state)
            ST_IDLE: begin
                if (InValid && InReady) begin
                    bus_w_next = alu_res;
                    zero_next  = (alu_res == '0);
                    ovf_next   = alu_ovf;
                    ill_next   = alu_ill;
                    state_next = ST_DONE;
`ifndef ALU_FAST_SHIFT_EN
                    if (is_shift) begin
                        op_next  = ALUCtrl;
                        cnt_next = Shamt;
                        if (Shamt != '0) state_next = ST_SHIFT;
                    end
`else
                    if (is_shift) state_next = ST_DONE;
`endif
                end
            end
`ifndef ALU_FAST_SHIFT_EN
            ST_SHIFT: begin
                bus_w_next = step;
                zero_next  = (step == '0);
                cnt_next   = cnt - SHAMT_W'(1);
                if (cnt == SHAMT_W'(1)) state_next = ST_DONE;
            end
`endif
            ST_DONE: begin
                if (OutReady) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State and output registers; handshake outputs track the next state
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state    <= ST_IDLE;
            InReady  <= 1'b0;
            OutValid <= 1'b0;
            BusW     <= '0;
            Zero     <= 1'b1;
            Overflow <= 1'b0;
            Illegal  <= 1'b0;
`ifndef ALU_FAST_SHIFT_EN
            cnt      <= '0;
            op_q     <= '0;
`endif
        end else begin
            state    <= state_next;
            InReady  <= (state_next == ST_IDLE);
            OutValid <= (state_next == ST_DONE);
            BusW     <= bus_w_next;
            Zero     <= zero_next;
            Overflow <= ovf_next;
            Illegal  <= ill_next;
`ifndef ALU_FAST_SHIFT_EN
            cnt      <= cnt_next;
            op_q     <= op_next;
`endif
        end
    end

endmodule
